// File: rtl/toaplan2_gcu_pkg.sv
// -----------------------------------------------------------------------------
// toaplan2_gcu_pkg
// Shared definitions for the 68k -> GP9001 (GCU) access bridge:
//   - register byte offsets inside one GP9001 window
//   - bridge FSM state encoding
//   - op index encoding (bit position of each op vector in the op array)
//   - decode_access(): maps a 68k access (direction + byte offset) onto a GCU op
// -----------------------------------------------------------------------------
package toaplan2_gcu_pkg;

  // Register byte offsets (ADDR carries bits [3:1] of these)
  localparam logic [3:0] REG_RAM_PTR    = 4'h0;
  localparam logic [3:0] REG_RAM_DATA_H = 4'h4;
  localparam logic [3:0] REG_RAM_DATA_L = 4'h6;
  localparam logic [3:0] REG_REG_SEL    = 4'h8;
  localparam logic [3:0] REG_REG_DATA   = 4'hC;

  localparam int NUM_OPS = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OPI_SELECT_REG  = 3'd0,
    OPI_WRITE_REG   = 3'd1,
    OPI_WRITE_RAM   = 3'd2,
    OPI_READ_RAM_H  = 3'd3,
    OPI_READ_RAM_L  = 3'd4,
    OPI_SET_RAM_PTR = 3'd5
  } op_e;

  typedef struct packed {
    logic mapped;
    op_e  op;
  } dec_t;

  // rw: 1 = read. Offsets with no GCU side effect return mapped = 0.
  function automatic dec_t decode_access(input logic rw, input logic [3:0] off);
    dec_t d;
    d.mapped = 1'b1;
    d.op     = OPI_SELECT_REG;
    if (rw) begin
      case (off)
        REG_RAM_DATA_H: d.op = OPI_READ_RAM_H;
        REG_RAM_DATA_L: d.op = OPI_READ_RAM_L;
        default:        d.mapped = 1'b0;
      endcase
    end else begin
      case (off)
        REG_RAM_PTR:                    d.op = OPI_SET_RAM_PTR;
        REG_RAM_DATA_H, REG_RAM_DATA_L: d.op = OPI_WRITE_RAM;
        REG_REG_SEL:                    d.op = OPI_SELECT_REG;
        REG_REG_DATA:                   d.op = OPI_WRITE_REG;
        default:                        d.mapped = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/toaplan2_gcu_timeout.sv
// -----------------------------------------------------------------------------
// toaplan2_gcu_timeout
// ACK watchdog for the GCU bridge. Counter is cleared in the cycle an op is
// issued, so the first WAIT_ACK cycle sees 0; it counts every WAIT_ACK cycle
// and flags expiry in the cycle it holds TIMEOUT-1 (i.e. the TIMEOUT-th cycle
// the op has been high).
// Ports:
//   clk_i      - clock (CLK96)
//   rst_i      - synchronous active-high reset
//   start_i    - op issued this cycle (next state is WAIT_ACK)
//   active_i   - bridge is in WAIT_ACK
//   expired_o  - combinational: ACK wait limit reached this cycle
// -----------------------------------------------------------------------------
module toaplan2_gcu_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/toaplan2_gcu_bridge.sv
// -----------------------------------------------------------------------------
// toaplan2_gcu_bridge
// Converts 68k accesses to a GP9001 register window into single-cycle-issued,
// ACK-terminated op levels on one of NUM_GCU GP9001 channels, and returns the
// read data / status to the CPU.
//
// Ports:
//   CLK96, RESET96   - clock, synchronous active-high reset
//   CS, RW, ADDR     - 68k access: region select (held for the access),
//                      1 = read, byte offset bits [3:1]
//   GCU_SEL          - channel index for the access
//   INT_N            - vblank interrupt (active low), readable at offset 0xC
//   DIN              - CPU write data (routed to the GCUs outside this block)
//   DOUT             - read data, holds between captures
//   BUSY             - CS && state != DONE, feeds DTACK generation
//   OP_*             - per-channel op levels, at most one bit high overall
//   ACK, GCU_DOUT    - per-channel op acknowledge and read data
//   TIMEOUT_ERR      - sticky ACK timeout flag
//
// Op handshake: an op bit is a level that rises the cycle after the access is
// decoded in IDLE and stays high until ACK of the same channel is sampled 1
// at a clock edge; the bit drops on that edge. ACK on other channels is
// ignored. An op is never withdrawn early, even if CS goes away.
//
// Build option: define TOAPLAN2_GCU_TIMEOUT_EN to add the ACK watchdog
// (TIMEOUT cycles). Without it WAIT_ACK waits forever and TIMEOUT_ERR is 0.
// -----------------------------------------------------------------------------
module toaplan2_gcu_bridge
  import toaplan2_gcu_pkg::*;
#(
  parameter int NUM_GCU = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                  CLK96,
  input  logic                  RESET96,
  input  logic                  CS,
  input  logic                  RW,
  input  logic [2:0]            ADDR,
  input  logic [1:0]            GCU_SEL,
  input  logic                  INT_N,
  input  logic [15:0]           DIN,
  output logic [15:0]           DOUT,
  output logic                  BUSY,
  output logic [NUM_GCU-1:0]    OP_SELECT_REG,
  output logic [NUM_GCU-1:0]    OP_WRITE_REG,
  output logic [NUM_GCU-1:0]    OP_WRITE_RAM,
  output logic [NUM_GCU-1:0]    OP_READ_RAM_H,
  output logic [NUM_GCU-1:0]    OP_READ_RAM_L,
  output logic [NUM_GCU-1:0]    OP_SET_RAM_PTR,
  input  logic [NUM_GCU-1:0]    ACK,
  input  logic [16*NUM_GCU-1:0] GCU_DOUT,
  output logic                  TIMEOUT_ERR
);

  state_e                           state_q;
  logic [NUM_OPS-1:0][NUM_GCU-1:0]  ops_q;
  logic [15:0]                      dout_q;
  logic [1:0]                       sel_q;   // channel of the op in flight
  logic                             rd_q;    // op in flight is a read

  logic [3:0]         byte_off;
  dec_t               dec;
  logic               sel_ok;
  logic               status_rd;
  logic               issue;
  logic [NUM_GCU-1:0] sel_onehot;
  logic               ack_sel;
  logic [15:0]        rd_data_sel;
  logic               expired;

  assign byte_off  = {ADDR, 1'b0};
  assign dec       = decode_access(RW, byte_off);
  assign sel_ok    = (32'(GCU_SEL) < NUM_GCU);
  assign status_rd = RW && (byte_off == REG_REG_DATA);
  assign issue     = (state_q == ST_IDLE) && CS && sel_ok && !status_rd && dec.mapped;

  // Channel muxing done with a loop so an out-of-range index never reaches
  // ACK / GCU_DOUT when NUM_GCU < 4.
  always_comb begin
    sel_onehot  = '0;
    ack_sel     = 1'b0;
    rd_data_sel = 16'h0000;
    for (int k = 0; k < NUM_GCU; k++) begin
      if (GCU_SEL == 2'(k)) sel_onehot[k] = 1'b1;
      if (sel_q == 2'(k)) begin
        ack_sel     = ACK[k];
        rd_data_sel = GCU_DOUT[16*k +: 16];
      end
    end
  end

`ifdef TOAPLAN2_GCU_TIMEOUT_EN
  logic tmo_err_q;

  toaplan2_gcu_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (CLK96),
    .rst_i     (RESET96),
    .start_i   (issue),
    .active_i  (state_q == ST_WAIT_ACK),
    .expired_o (expired)
  );

  assign TIMEOUT_ERR = tmo_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign expired        = 1'b0;
  assign TIMEOUT_ERR    = 1'b0;
`endif

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q <= ST_IDLE;
      ops_q   <= '0;
      dout_q  <= 16'h0000;
      sel_q   <= 2'd0;
      rd_q    <= 1'b0;
`ifdef TOAPLAN2_GCU_TIMEOUT_EN
      tmo_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CS) begin
            sel_q <= GCU_SEL;
            rd_q  <= RW;
            if (!sel_ok) begin
              if (RW) dout_q <= 16'hFFFF;
              state_q <= ST_DONE;
            end else if (status_rd) begin
              dout_q  <= {15'b0, ~INT_N};
              state_q <= ST_DONE;
            end else if (issue) begin
              ops_q[dec.op] <= sel_onehot;
              state_q       <= ST_WAIT_ACK;
            end else begin
              if (RW) dout_q <= 16'h0000;
              state_q <= ST_DONE;
            end
          end
        end
        ST_WAIT_ACK: begin
          // ACK wins over a simultaneous expiry: the data is real.
          if (ack_sel || expired) begin
            ops_q <= '0;
            if (rd_q) dout_q <= ack_sel ? rd_data_sel : 16'hFFFF;
`ifdef TOAPLAN2_GCU_TIMEOUT_EN
            if (!ack_sel) tmo_err_q <= 1'b1;
`endif
            state_q <= CS ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          // Stay here until the CPU ends the access: one op per access.
          if (!CS) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic unused_din;
  assign unused_din = ^DIN;

  assign OP_SELECT_REG  = ops_q[OPI_SELECT_REG];
  assign OP_WRITE_REG   = ops_q[OPI_WRITE_REG];
  assign OP_WRITE_RAM   = ops_q[OPI_WRITE_RAM];
  assign OP_READ_RAM_H  = ops_q[OPI_READ_RAM_H];
  assign OP_READ_RAM_L  = ops_q[OPI_READ_RAM_L];
  assign OP_SET_RAM_PTR = ops_q[OPI_SET_RAM_PTR];
  assign DOUT           = dout_q;
  assign BUSY           = CS && (state_q != ST_DONE);

endmodule

// File: doc/toaplan2_gcu_bridge.md
TOAPLAN2_GCU_BRIDGE -- requirements
Module: toaplan2_gcu_bridge

Interface
REQ-001 SHALL have parameter NUM_GCU, default 1, range 1..4: number of GP9001 channels served.
REQ-002 SHALL have parameter TIMEOUT, default 1024: ACK wait limit in CLK96 cycles (used only under the timeout feature).
REQ-003 Port list (name, direction, width, meaning):
- CLK96, in, 1: the one clock.
- RESET96, in, 1: synchronous, active-high reset.
- CS, in, 1: decoded GP9001 region select, held for the whole 68k access.
- RW, in, 1: 1 = read, 0 = write.
- ADDR, in, 3: byte offset bits [3:1] of the register.
- GCU_SEL, in, 2: target channel index.
- INT_N, in, 1: vblank interrupt line, active low.
- DIN, in, 16: CPU write data, passed through externally.
- DOUT, out, 16: read data for the CPU.
- BUSY, out, 1: feeds bus_busy for DTACK generation.
- OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L, OP_SET_RAM_PTR: each out, NUM_GCU, one-hot per channel op levels.
- ACK, in, NUM_GCU: per-channel op acknowledge.
- GCU_DOUT, in, 16*NUM_GCU: per-channel read data; channel k occupies [16k+15:16k].
- TIMEOUT_ERR, out, 1: sticky ACK-timeout flag.

Function
REQ-004 SHALL implement the states IDLE, WAIT_ACK and DONE.
REQ-005 In IDLE with CS=1, the offset SHALL map to an op:
- Write 0x0 -> SET_RAM_PTR.
- Write 0x4 or 0x6 -> WRITE_RAM.
- Write 0x8 -> SELECT_REG.
- Write 0xC -> WRITE_REG.
- Read 0x4 -> READ_RAM_H.
- Read 0x6 -> READ_RAM_L.
REQ-006 For a mapped op with GCU_SEL<NUM_GCU, the matching op bit [GCU_SEL] SHALL rise on the next cycle, and the state SHALL go to WAIT_ACK.
REQ-007 Any op bit SHALL stay high until ACK[GCU_SEL] is sampled 1. In that same cycle the block SHALL register the op low, capture the selected GCU_DOUT slice into DOUT on a read, and move to DONE, or to IDLE if CS=0.
REQ-008 An unmapped access (read 0x0/0x2/0x8/0xA, write 0x2/0xA/0xE) SHALL go directly to DONE with no op. On a read, DOUT SHALL be 0x0000.
REQ-009 A read of 0xC SHALL go directly to DONE with DOUT={15'b0,~INT_N}, sampled in the IDLE cycle.
REQ-010 GCU_SEL>=NUM_GCU SHALL go directly to DONE with no op. On a read, DOUT SHALL be 0xFFFF.
REQ-011 BUSY SHALL equal CS && (state!=DONE), combinationally. Minimum BUSY is 1 cycle for immediate accesses and 2 cycles for a GCU op whose ACK arrives in the cycle after the op rises.
REQ-012 DONE SHALL return to IDLE when CS=0. While CS stays 1, no new op SHALL be issued, so there is exactly one op per access.
REQ-013 If CS drops during WAIT_ACK, the op SHALL still be held until ACK (the GCU cannot be aborted), and the state SHALL then go to IDLE.
REQ-014 ACK on a non-selected channel SHALL be ignored. At most one op bit across all vectors SHALL be high at any time.
REQ-015 DOUT SHALL hold its last value outside capture events.

Reset
REQ-016 RESET96=1 at a clock edge SHALL force:
- state to IDLE;
- all op vectors to 0;
- DOUT to 0x0000;
- TIMEOUT_ERR to 0;
- the timeout counter to 0.
This SHALL apply also mid-WAIT_ACK. Reset SHALL take priority over all other events.

Configuration
REQ-017 Macro TOAPLAN2_GCU_TIMEOUT_EN.
- Defined: the counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle. When it reaches TIMEOUT-1 with no ACK, the op SHALL drop, DOUT SHALL become 0xFFFF on a read, TIMEOUT_ERR SHALL set (sticky until reset), and the state SHALL go to DONE or IDLE per CS.
- Undefined: WAIT_ACK SHALL wait indefinitely, and TIMEOUT_ERR SHALL be tied to 0.

Structure
REQ-018 Package toaplan2_gcu_pkg SHALL hold:
- the register offset constants (0x0, 0x4, 0x6, 0x8, 0xC);
- the state enum;
- the op-index enum, ordered SELECT_REG, WRITE_REG, WRITE_RAM, READ_RAM_H, READ_RAM_L, SET_RAM_PTR.
REQ-019 Sub-module toaplan2_gcu_timeout SHALL contain the counter and expiry compare. It SHALL be instantiated only under TOAPLAN2_GCU_TIMEOUT_EN.

Verification
REQ-020 NUM_GCU=2, write 0x8 with GCU_SEL=1, ACK[1] 3 cycles after the op rises -> OP_SELECT_REG=2'b10 for 3 cycles, and BUSY falls the cycle after ACK.
REQ-021 Read 0x4 with GCU_SEL=0, GCU_DOUT[15:0]=0xBEEF, ACK on the next cycle -> OP_READ_RAM_H[0] high for 1 cycle, DOUT=0xBEEF, and BUSY high for 2 cycles.
REQ-022 Read 0xC with INT_N=0 -> DOUT=0x0001, BUSY high for 1 cycle, and all op vectors stay 0; repeat with INT_N=1 -> DOUT=0x0000.
REQ-023 NUM_GCU=1, read 0x6 with GCU_SEL=2 -> DOUT=0xFFFF and no op; then write 0x0 with CS dropped mid-WAIT_ACK -> op held until ACK, then IDLE.
REQ-024 With TOAPLAN2_GCU_TIMEOUT_EN and TIMEOUT=16, read 0x6 with ACK never asserted -> op drops after 16 cycles, DOUT=0xFFFF, and TIMEOUT_ERR=1 until RESET96.
REQ-025 RESET96 pulsed during WAIT_ACK -> next cycle all ops are 0 and the state is IDLE; a following access completes normally.
